// File: rtl/sd3_frame_ser_if.sv
// Handshake and serial-output bundle for sd3_frame_ser.
// slave = serializer side, master = frame producer / detector side.
interface sd3_frame_ser_if #(
    parameter int SER_W = 6
);
    logic [SER_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_data;
    logic             frame_start;
    logic             underrun;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_data, frame_start, underrun
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_data, frame_start, underrun
    );
endinterface

// File: rtl/sd3_frame_ser.sv
// 6-bit frame serializer with 2-entry FIFO and all-ones idle fill on underrun.
// Optional SER_LSB_FIRST_EN: LSB-first order, done by bit-reversing words at FIFO write.
module sd3_frame_ser #(
    parameter int               SER_W     = 6,
    parameter logic [SER_W-1:0] IDLE_WORD = '1
) (
    input logic            clk,
    input logic            rst_n,
    sd3_frame_ser_if.slave bus
);
    localparam logic [2:0] LAST_IDX = 3'(SER_W - 1);

    logic [SER_W-1:0] shreg;
    logic [SER_W-1:0] fifo_mem [2];
    logic [SER_W-1:0] wr_word;
    logic [2:0]       bit_idx;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             underrun_q;
    logic             boundary;
    logic             push;
    logic             pop;

`ifdef SER_LSB_FIRST_EN
    always_comb begin
        wr_word = '0;
        for (int unsigned i = 0; i < SER_W; i++) begin
            wr_word[i] = bus.in_data[SER_W-1-i];
        end
    end
`else
    assign wr_word = bus.in_data;
`endif

    // Push qualifies on registered count only, so a same-edge pop never frees a slot.
    always_comb begin
        boundary = (bit_idx == LAST_IDX);
        push     = bus.in_valid && (count != 2'd2);
        pop      = boundary && (count != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wr_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= IDLE_WORD;
            bit_idx    <= '0;
            underrun_q <= 1'b0;
        end else if (boundary) begin
            bit_idx <= '0;
            if (pop) begin
                shreg      <= fifo_mem[rd_ptr];
                underrun_q <= 1'b0;
            end else begin
                shreg      <= IDLE_WORD;
                underrun_q <= 1'b1;
            end
        end else begin
            shreg      <= {shreg[SER_W-2:0], 1'b1};
            bit_idx    <= bit_idx + 3'd1;
            underrun_q <= 1'b0;
        end
    end

    assign bus.ser_data    = shreg[SER_W-1];
    assign bus.frame_start = (bit_idx == 3'd0);
    assign bus.in_ready    = (count != 2'd2);
    assign bus.underrun    = underrun_q;
endmodule

// File: tb/tb_sd3_frame_ser.sv
// Self-checking bench for sd3_frame_ser: frame-level model plus literal frame checks.
// Honours SER_LSB_FIRST_EN for expected bit order.
module tb_sd3_frame_ser;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sd3_frame_ser_if #(.SER_W(6)) bus ();

    sd3_frame_ser #(
        .SER_W    (6),
        .IDLE_WORD(6'b111111)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transmission order of a word as it should appear on the wire, first bit at [5].
    function automatic logic [5:0] wire_order(logic [5:0] w);
        logic [5:0] r;
`ifdef SER_LSB_FIRST_EN
        for (int i = 0; i < 6; i++) r[5-i] = w[i];
`else
        r = w;
`endif
        return r;
    endfunction

    // Frame-level model: cycle t since release, frames every 6 cycles, queue of waiting words.
    logic [5:0] m_q [$];
    logic [5:0] m_cur;
    bit         m_idle;
    int         t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cur  = 6'b111111;
            m_idle = 1'b1;
            t      = 0;
        end else begin
            bit acc;
            acc = bus.in_valid && (m_q.size() < 2);
            if (t % 6 == 5) begin
                if (m_q.size() > 0) begin
                    m_cur  = m_q.pop_front();
                    m_idle = 1'b0;
                end else begin
                    m_cur  = 6'b111111;
                    m_idle = 1'b1;
                end
            end
            if (acc) m_q.push_back(bus.in_data);
            t++;
        end
    end

    logic obs_ser [64];
    logic obs_fs  [64];
    logic obs_ur  [64];
    logic obs_rdy [64];

    always @(negedge clk) begin
        if (rst_n) begin
            int         pos;
            logic [5:0] wo;
            pos = t % 6;
            wo  = wire_order(m_cur);
            chk("ser_data",    bus.ser_data,    wo[5-pos]);
            chk("frame_start", bus.frame_start, (pos == 0));
            chk("underrun",    bus.underrun,    (t > 0 && pos == 0 && m_idle));
            chk("in_ready",    bus.in_ready,    (m_q.size() < 2));
            if (t < 64) begin
                obs_ser[t] = bus.ser_data;
                obs_fs[t]  = bus.frame_start;
                obs_ur[t]  = bus.underrun;
                obs_rdy[t] = bus.in_ready;
            end
        end
    end

    function automatic logic [5:0] frame_at(int c);
        logic [5:0] f;
        for (int i = 0; i < 6; i++) f[5-i] = obs_ser[c+i];
        return f;
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < 64; i++) begin
            obs_ser[i] = 1'b0;
            obs_fs[i]  = 1'b0;
            obs_ur[i]  = 1'b0;
            obs_rdy[i] = 1'b0;
        end
    endtask

    task automatic release_reset();
        clear_obs();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic go_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic wait_cycle(int c);
        int n;
        n = 0;
        while (t != c && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (t != c) chk("wait_cycle", t, c);
    endtask

    task automatic send(logic [5:0] w);
        logic hs;
        int   n;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         all_one;
        int         fs_cnt;

        // 1: idle stream after reset
        go_reset();
        chk("t1_reset_ser", bus.ser_data, 1);
        chk("t1_reset_fs",  bus.frame_start, 1);
        chk("t1_reset_rdy", bus.in_ready, 1);
        chk("t1_reset_ur",  bus.underrun, 0);
        wait_cycle(24);
        all_one = 1'b1;
        fs_cnt  = 0;
        for (int c = 0; c < 24; c++) begin
            all_one &= obs_ser[c];
            if (obs_fs[c]) fs_cnt++;
        end
        chk("t1_ser_all_ones", all_one, 1);
        chk("t1_fs_count", fs_cnt, 4);
        chk("t1_fs_18", obs_fs[18], 1);
        chk("t1_ur_0",  obs_ur[0], 0);
        chk("t1_ur_6",  obs_ur[6], 1);
        chk("t1_ur_12", obs_ur[12], 1);
        chk("t1_ur_18", obs_ur[18], 1);

        // 2: single frame pushed at cycle 2
        go_reset();
        wait_cycle(2);
        send(6'b011100);
        wait_cycle(14);
        chk("t2_frame6", frame_at(6), wire_order(6'b011100));
        chk("t2_fs_6",   obs_fs[6], 1);
        chk("t2_ur_6",   obs_ur[6], 0);
        chk("t2_ur_12",  obs_ur[12], 1);

        // 3: back-pressure, three pushes from cycle 1
        go_reset();
        wait_cycle(1);
        send(6'b011100);
        send(6'b000000);
        send(6'b101010);
        wait_cycle(26);
        chk("t3_rdy_2",  obs_rdy[2], 1);
        chk("t3_rdy_3",  obs_rdy[3], 0);
        chk("t3_rdy_5",  obs_rdy[5], 0);
        chk("t3_rdy_6",  obs_rdy[6], 1);
        chk("t3_frame6",  frame_at(6),  wire_order(6'b011100));
        chk("t3_frame12", frame_at(12), wire_order(6'b000000));
        chk("t3_frame18", frame_at(18), wire_order(6'b101010));
        chk("t3_ur_12", obs_ur[12], 0);
        chk("t3_ur_24", obs_ur[24], 1);

        // 4: push into empty FIFO on the boundary edge
        go_reset();
        wait_cycle(5);
        send(6'b010011);
        wait_cycle(20);
        chk("t4_frame6_idle", frame_at(6), 6'b111111);
        chk("t4_ur_6",   obs_ur[6], 1);
        chk("t4_frame12", frame_at(12), wire_order(6'b010011));
        chk("t4_ur_12",  obs_ur[12], 0);

        // 5: reset mid-operation with two words buffered
        go_reset();
        wait_cycle(1);
        send(6'b000000);
        send(6'b010101);
        send(6'b001100);
        wait_cycle(9);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ser", bus.ser_data, 1);
        chk("t5_rst_fs",  bus.frame_start, 1);
        chk("t5_rst_rdy", bus.in_ready, 1);
        chk("t5_rst_ur",  bus.underrun, 0);
        @(posedge clk);
        release_reset();
        wait_cycle(25);
        all_one = 1'b1;
        for (int c = 0; c < 24; c++) all_one &= obs_ser[c];
        chk("t5_no_stale_word", all_one, 1);
        chk("t5_ur_6",  obs_ur[6], 1);
        chk("t5_ur_12", obs_ur[12], 1);

        // 6: bit order
        go_reset();
        wait_cycle(2);
        send(6'b000111);
        wait_cycle(13);
`ifdef SER_LSB_FIRST_EN
        chk("t6_order", frame_at(6), 6'b111000);
`else
        chk("t6_order", frame_at(6), 6'b000111);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
